seq_mult_param: RTL and testbench

Parametrised sequential shift-add multiplier. It is the next generation of the fixed 8x8 start/done multiplier in our top-level datapath.
- Generalised operand width.
- Adds a per-operation signed/unsigned mode.
- Adds a busy indicator and an explicit operand lock.
It sits between the operand input registers and the result/display logic. `locked` gates the tri-state operand bus; `done_flag` strobes the result consumer.

---
 rtl/seq_mult_pkg.sv | 29 ++
 rtl/seq_mult_param_if.sv | 22 ++
 rtl/seq_mult_sign.sv | 25 ++
 rtl/seq_mult_param.sv | 115 +++++++++++
 tb/tb_seq_mult_param.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared types and helpers for the seq_mult_param multiplier.
//   state_e : FSM encoding (S_IDLE, S_RUN, S_DONE)
//   mag_f   : magnitude of a w-bit value, treating it as two's complement
//             when sgn = 1, otherwise returning it unchanged.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int MAX_W = 64;

  // v holds a w-bit value zero-extended to MAX_W. The most-negative value
  // maps to 2^(w-1), which still fits in w unsigned bits.
  function automatic logic [MAX_W-1:0] mag_f(input logic [MAX_W-1:0] v,
                                             input int unsigned     w,
                                             input logic            sgn);
    logic [MAX_W-1:0] ones;
    logic [MAX_W-1:0] msk;
    ones = '1;
    msk  = ones;
    if (w < MAX_W) msk = ~(ones << w);
    if (sgn && v[6'(w - 1)]) return (-v) & msk;
    else                     return v & msk;
  endfunction

endpackage

// File: rtl/seq_mult_param_if.sv
// seq_mult_param_if: operand/result bundle of the sequential multiplier.
//   start, signed_mode, a, b : request side (driven by master)
//   locked, busy, done_flag  : status (driven by slave)
//   d_out                    : 2*WIDTH-bit product (driven by slave)
interface seq_mult_param_if #(parameter int WIDTH = 8) ();

  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               locked;
  logic               busy;
  logic               done_flag;
  logic [2*WIDTH-1:0] d_out;

  modport master (output start, signed_mode, a, b,
                  input  locked, busy, done_flag, d_out);

  modport slave  (input  start, signed_mode, a, b,
                  output locked, busy, done_flag, d_out);

endinterface

// File: rtl/seq_mult_sign.sv
// seq_mult_sign: combinational sign helper.
//   abs_mode = 1 : res = |val| when ctrl (signed mode) and val's MSB are set,
//                  else val.
//   abs_mode = 0 : res = -val when ctrl is set, else val.
// Ports: val[W-1:0], ctrl, abs_mode in; res[W-1:0] out.
module seq_mult_sign
  import seq_mult_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] val,
  input  logic         ctrl,
  input  logic         abs_mode,
  output logic [W-1:0] res
);

  localparam int unsigned WU = W;

  always_comb begin
    res = val;
    if (abs_mode) res = W'(mag_f(MAX_W'(val), WU, ctrl));
    else if (ctrl) res = -val;
  end

endmodule

// File: rtl/seq_mult_param.sv
// seq_mult_param: parametrised shift-add multiplier with start/done handshake.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : seq_mult_param_if.slave (start, signed_mode, a, b in;
//              locked, busy, done_flag, d_out out)
// Operands are converted to magnitudes on capture, multiplied unsigned one
// multiplier bit per cycle, and the sign is reapplied on the final edge.
// Optional build macro SEQ_MULT_EARLY_EXIT_EN: leave RUN as soon as the
// remaining multiplier bits are all zero instead of always taking WIDTH edges.
module seq_mult_param
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  seq_mult_param_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = 2 * WIDTH;

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             neg_q,    neg_d;
  logic [PW-1:0]    acc_q,    acc_d;
  logic [PW-1:0]    d_out_q,  d_out_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    acc_nxt, prod_fix;
  logic             last_bit;

  seq_mult_sign #(.W(WIDTH)) u_abs_a (
    .val(bus.a), .ctrl(bus.signed_mode), .abs_mode(1'b1), .res(a_mag));

  seq_mult_sign #(.W(WIDTH)) u_abs_b (
    .val(bus.b), .ctrl(bus.signed_mode), .abs_mode(1'b1), .res(b_mag));

  // Sign correction sees acc_nxt so the result lands on the same edge that
  // folds in the final partial product.
  seq_mult_sign #(.W(PW)) u_fix (
    .val(acc_nxt), .ctrl(neg_q), .abs_mode(1'b0), .res(prod_fix));

  always_comb begin
    acc_nxt = acc_q;
    if (mplier_q[0]) acc_nxt = acc_q + (PW'(mcand_q) << cnt_q);
  end

`ifdef SEQ_MULT_EARLY_EXIT_EN
  // No set bits left above the current one: nothing more to add.
  assign last_bit = (mplier_q[WIDTH-1:1] == '0);
`else
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    d_out_d  = d_out_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d    = acc_nxt;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          d_out_d = prod_fix;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      d_out_q  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      d_out_q  <= d_out_d;
    end
  end

  assign bus.locked    = (state_q == S_RUN);
  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign bus.done_flag = (state_q == S_DONE);
  assign bus.d_out     = d_out_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: directed bench for seq_mult_param at WIDTH=8 and 16.
// A timeline model (accept edge + operation length, plain arithmetic product)
// is compared against both DUTs every cycle; directed tests add literal
// expectations for products, latencies and reset/abort behaviour.
module tb_seq_mult_param;

`ifdef SEQ_MULT_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8, rst16;

  seq_mult_param_if #(.WIDTH(8))  if8 ();
  seq_mult_param_if #(.WIDTH(16)) if16 ();

  seq_mult_param #(.WIDTH(8))  u8  (.clk(clk), .rst(rst8),  .bus(if8));
  seq_mult_param #(.WIDTH(16)) u16 (.clk(clk), .rst(rst16), .bus(if16));

  int tot = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic get_locked(input int id);
    return (id == 0) ? if8.locked : if16.locked;
  endfunction
  function automatic logic get_busy(input int id);
    return (id == 0) ? if8.busy : if16.busy;
  endfunction
  function automatic logic get_done(input int id);
    return (id == 0) ? if8.done_flag : if16.done_flag;
  endfunction
  function automatic logic [63:0] get_dout(input int id);
    return (id == 0) ? 64'(if8.d_out) : 64'(if16.d_out);
  endfunction

  task automatic drive(input int id, input logic st, input logic sm,
                       input logic [31:0] av, input logic [31:0] bv);
    if (id == 0) begin
      if8.start = st; if8.signed_mode = sm; if8.a = av[7:0]; if8.b = bv[7:0];
    end else begin
      if16.start = st; if16.signed_mode = sm; if16.a = av[15:0]; if16.b = bv[15:0];
    end
  endtask

  task automatic set_start(input int id, input logic st);
    if (id == 0) if8.start = st; else if16.start = st;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] mdl_prod(input logic [31:0] av, input logic [31:0] bv,
                                           input logic sm, input int w);
    longint sa, sb;
    logic [63:0] msk, p;
    msk = (64'd1 << (2 * w)) - 64'd1;
    sa  = longint'(av);
    sb  = longint'(bv);
    if (sm && av[w-1]) sa = sa - (longint'(1) << w);
    if (sm && bv[w-1]) sb = sb - (longint'(1) << w);
    p = 64'(sa * sb);
    return p & msk;
  endfunction

  // Number of RUN edges for an operation.
  function automatic int mdl_len(input logic [31:0] bv, input logic sm, input int w);
    logic [32:0] mag;
    int n;
    if (!EE) return w;
    mag = (sm && bv[w-1]) ? ((33'd1 << w) - 33'(bv)) : 33'(bv);
    n = 0;
    while (mag != 0) begin n++; mag = mag >> 1; end
    return (n == 0) ? 1 : n;
  endfunction

  int unsigned edge_n = 0;
  bit          mdl_ok = 1'b0;
  bit          m_act [2];
  int unsigned m_k   [2];
  int unsigned m_n   [2];
  logic [63:0] m_prod[2];
  logic [63:0] e_dout[2];
  bit          e_lock[2], e_busy[2], e_done[2];

  always @(posedge clk) begin
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      logic st, sm, r;
      logic [31:0] av, bv;
      int w;
      int unsigned d;
      st = (i == 0) ? if8.start : if16.start;
      sm = (i == 0) ? if8.signed_mode : if16.signed_mode;
      av = (i == 0) ? 32'(if8.a) : 32'(if16.a);
      bv = (i == 0) ? 32'(if8.b) : 32'(if16.b);
      r  = (i == 0) ? rst8 : rst16;
      w  = (i == 0) ? 8 : 16;
      if (r) begin
        m_act[i]  = 1'b0;
        e_dout[i] = '0;
      end else if (st && (!m_act[i] || (edge_n - 1 - m_k[i]) >= m_n[i] + 1)) begin
        m_act[i]  = 1'b1;
        m_k[i]    = edge_n;
        m_n[i]    = mdl_len(bv, sm, w);
        m_prod[i] = mdl_prod(av, bv, sm, w);
      end
      e_lock[i] = 1'b0; e_busy[i] = 1'b0; e_done[i] = 1'b0;
      if (m_act[i]) begin
        d = edge_n - m_k[i];
        e_lock[i] = (d < m_n[i]);
        e_busy[i] = (d <= m_n[i]);
        e_done[i] = (d == m_n[i]);
        if (d == m_n[i]) e_dout[i] = m_prod[i];
      end
    end
    mdl_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (mdl_ok) begin
      for (int i = 0; i < 2; i++) begin
        string tg;
        tg = (i == 0) ? "w8" : "w16";
        chk($sformatf("model_locked_%s", tg), 64'(get_locked(i)), 64'(e_lock[i]));
        chk($sformatf("model_busy_%s", tg),   64'(get_busy(i)),   64'(e_busy[i]));
        chk($sformatf("model_done_%s", tg),   64'(get_done(i)),   64'(e_done[i]));
        chk($sformatf("model_dout_%s", tg),   get_dout(i),        e_dout[i]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // lat = RUN edges before done_flag, lk = cycles with locked high.
  // poke > 0 changes operands and pulses start in that cycle of the operation.
  task automatic run_op(input int id, input logic [31:0] av, input logic [31:0] bv,
                        input logic sm, input int poke,
                        output int lat, output int lk, output logic [63:0] res);
    @(negedge clk);
    drive(id, 1'b1, sm, av, bv);
    lat = 0; lk = 0; res = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) set_start(id, 1'b0);
      if (poke > 0 && c == poke) drive(id, 1'b1, ~sm, ~av, ~bv);
      if (poke > 0 && c == poke + 1) set_start(id, 1'b0);
      if (get_locked(id)) lk++;
      if (get_done(id)) begin lat = c - 1; res = get_dout(id); break; end
    end
    if (lat == 0) begin
      tot++; bad++;
      $display("FAIL run_op_timeout: no done_flag within 60 cycles (a=%h b=%h)", av, bv);
    end
  endtask

  task automatic count_dones(input int id, input int n, output int cnt);
    cnt = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (get_done(id)) cnt++;
    end
  endtask

  initial begin
    int lat, lk, cnt, c1, c2;
    logic [63:0] res, r1, r2;
    rst8 = 1'b1; rst16 = 1'b1;
    drive(0, 1'b0, 1'b0, 0, 0);
    drive(1, 1'b0, 1'b0, 0, 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_locked", 64'(get_locked(i)), 64'd0);
      chk("reset_busy",   64'(get_busy(i)),   64'd0);
      chk("reset_done",   64'(get_done(i)),   64'd0);
      chk("reset_dout",   get_dout(i),        64'd0);
    end
    rst8 = 1'b0; rst16 = 1'b0;
    @(negedge clk);

    // 129 * 19 = 2451
    run_op(0, 'h81, 'h13, 1'b0, 0, lat, lk, res);
    chk("u8_81x13", res, 64'h0993);
    chk("u8_81x13_lat", 64'(lat), EE ? 64'd5 : 64'd8);
    chk("u8_81x13_locked", 64'(lk), EE ? 64'd5 : 64'd8);

    // signed: (-128)^2, -1*3, 127*-127
    run_op(0, 'h80, 'h80, 1'b1, 0, lat, lk, res);
    chk("s8_80x80", res, 64'h4000);
    chk("s8_80x80_lat", 64'(lat), 64'd8);
    run_op(0, 'hFF, 'h03, 1'b1, 0, lat, lk, res);
    chk("s8_FFx03", res, 64'hFFFD);
    run_op(0, 'h7F, 'h81, 1'b1, 0, lat, lk, res);
    chk("s8_7Fx81", res, 64'hC0FF);
    chk("s8_7Fx81_lat", 64'(lat), EE ? 64'd7 : 64'd8);
    run_op(0, 'hFF, 'hFF, 1'b0, 0, lat, lk, res);
    chk("u8_FFxFF", res, 64'hFE01);

    // short multipliers (early-exit cases)
    run_op(0, 'h5A, 'h00, 1'b0, 0, lat, lk, res);
    chk("u8_b0", res, 64'h0000);
    chk("u8_b0_lat", 64'(lat), EE ? 64'd1 : 64'd8);
    run_op(0, 'h05, 'h03, 1'b0, 0, lat, lk, res);
    chk("u8_05x03", res, 64'h000F);
    chk("u8_05x03_lat", 64'(lat), EE ? 64'd2 : 64'd8);
    run_op(0, 'h02, 'hFF, 1'b1, 0, lat, lk, res);
    chk("s8_02xFF", res, 64'hFFFE);
    chk("s8_02xFF_lat", 64'(lat), EE ? 64'd1 : 64'd8);

    // operands changed and start pulsed mid-RUN: ignored, not queued
    run_op(0, 'h81, 'h13, 1'b0, 3, lat, lk, res);
    chk("midrun_result", res, 64'h0993);
    count_dones(0, 12, cnt);
    chk("midrun_no_second_done", 64'(cnt), 64'd0);

    // reset in RUN cycle 3 aborts and clears d_out
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 'h55, 'h66);
    @(negedge clk); set_start(0, 1'b0);
    @(negedge clk);
    @(negedge clk); rst8 = 1'b1;
    @(negedge clk); rst8 = 1'b0;
    chk("abort_locked", 64'(get_locked(0)), 64'd0);
    chk("abort_busy",   64'(get_busy(0)),   64'd0);
    chk("abort_done",   64'(get_done(0)),   64'd0);
    chk("abort_dout",   get_dout(0),        64'd0);
    count_dones(0, 12, cnt);
    chk("abort_no_done", 64'(cnt), 64'd0);
    run_op(0, 'h0A, 'h0C, 1'b0, 0, lat, lk, res);
    chk("after_abort", res, 64'h0078);

    // WIDTH=16
    run_op(1, 'h8000, 'h8000, 1'b1, 0, lat, lk, res);
    chk("s16_8000sq", res, 64'h4000_0000);
    run_op(1, 'hFFFF, 'h7FFF, 1'b1, 0, lat, lk, res);
    chk("s16_m1x7FFF", res, 64'hFFFF_8001);
    chk("s16_m1x7FFF_lat", 64'(lat), EE ? 64'd15 : 64'd16);

    // start held high: back-to-back, period WIDTH+2
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 'hFFFF, 'hFFFF);
    c1 = 0; c2 = 0; r1 = '0; r2 = '0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (get_done(1)) begin
        if (c1 == 0) begin c1 = c; r1 = get_dout(1); end
        else begin c2 = c; r2 = get_dout(1); set_start(1, 1'b0); break; end
      end
    end
    chk("u16_held_first_done", 64'(c1), 64'd17);
    chk("u16_held_period", 64'(c2 - c1), 64'd18);
    chk("u16_held_r1", r1, 64'hFFFE_0001);
    chk("u16_held_r2", r2, 64'hFFFE_0001);
    count_dones(1, 25, cnt);
    chk("u16_no_third", 64'(cnt), 64'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
